// File: rtl/hazard_fwd_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the hazard/forwarding controller
// Provides the forward-select encoding, the controller FSM states and the shadow-stage record.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } shadow_t;
endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: ID-stage request / pipeline-control bundle
// Inputs to the controller: ID instruction fields, ex_branch_taken, dmem_busy.
// Outputs from the controller: forward selects, PC/IF/ID/ID-EX controls, freeze, counters, timeout.
interface hazard_fwd_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) ();
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_branch_taken;
    logic             dmem_busy;
    fwd_sel_t         forward_a;
    fwd_sel_t         forward_b;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_reg_write, id_mem_read, ex_branch_taken, dmem_busy,
        input  forward_a, forward_b, pc_write, if_id_write, if_id_flush,
               id_ex_bubble, pipe_freeze, stall_count, flush_count, mem_timeout
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_reg_write, id_mem_read, ex_branch_taken, dmem_busy,
        output forward_a, forward_b, pc_write, if_id_write, if_id_flush,
               id_ex_bubble, pipe_freeze, stall_count, flush_count, mem_timeout
    );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_calc.sv
// fwd_sel_calc: operand match and forward-source priority for one EX operand
// Ports: i_used/i_rs (ID operand), i_ex_*/i_mem_* (shadow rd and reg_write),
//        o_sel (next forward select), o_ex_hit (EX shadow matches, used for load-use).
module fwd_sel_calc
    import pipe_ctrl_pkg::*;
(
    input  logic       i_used,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_wr,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_wr,
    output fwd_sel_t   o_sel,
    output logic       o_ex_hit
);
    logic w_mem_hit;

    assign o_ex_hit  = i_used && i_ex_wr && (i_ex_rd == i_rs) && (i_ex_rd != 5'd0);
    assign w_mem_hit = i_used && i_mem_wr && (i_mem_rd == i_rs) && (i_mem_rd != 5'd0);
    // the EX shadow holds the youngest producer, so it wins over MEM
    assign o_sel     = o_ex_hit ? FWD_EX_MEM : w_mem_hit ? FWD_MEM_WB : FWD_REG;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall, branch flush, dmem freeze and registered forwarding for the 5-stage core
// Ports: clk, rst_n (async active-low), bus (hazard_fwd_ctrl_if.slave carrying all ID inputs and control outputs).
module hazard_fwd_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_fwd_ctrl_if.slave bus
);
    localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    shadow_t          r_ex, r_mem, r_wb, w_id;
    fwd_sel_t         r_fa, r_fb, w_fa, w_fb;
    ctrl_state_t      r_state;
    logic [WC_W-1:0]  r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             r_timeout;
    logic             w_hit_a, w_hit_b, w_busy, w_flush, w_stall;

    fwd_sel_calc u_fwd_a (
        .i_used(bus.id_uses_rs1), .i_rs(bus.id_rs1),
        .i_ex_rd(r_ex.rd), .i_ex_wr(r_ex.reg_write),
        .i_mem_rd(r_mem.rd), .i_mem_wr(r_mem.reg_write),
        .o_sel(w_fa), .o_ex_hit(w_hit_a)
    );
    fwd_sel_calc u_fwd_b (
        .i_used(bus.id_uses_rs2), .i_rs(bus.id_rs2),
        .i_ex_rd(r_ex.rd), .i_ex_wr(r_ex.reg_write),
        .i_mem_rd(r_mem.rd), .i_mem_wr(r_mem.reg_write),
        .o_sel(w_fb), .o_ex_hit(w_hit_b)
    );

    assign w_busy  = bus.dmem_busy;
    assign w_flush = !w_busy && bus.ex_branch_taken;
    assign w_stall = !w_busy && !bus.ex_branch_taken && bus.id_valid && r_ex.mem_read && (w_hit_a || w_hit_b);
    assign w_id    = bus.id_valid ? shadow_t'{bus.id_rd, bus.id_reg_write, bus.id_mem_read} : '0;
    // counts consecutive busy cycles, the cycle that enters MEM_WAIT being the first
    assign w_wait_nxt = (r_state == RUN) ? WC_W'(1) : (r_wait_cnt == WC_MAX) ? WC_MAX : r_wait_cnt + 1'b1;

    assign bus.pipe_freeze  = !rst_n || w_busy;
    assign bus.pc_write     = rst_n && !w_busy && !w_stall;
    assign bus.if_id_write  = rst_n && !w_busy && !w_stall;
    assign bus.if_id_flush  = rst_n && w_flush;
    assign bus.id_ex_bubble = rst_n && (w_flush || w_stall);
    assign bus.forward_a    = r_fa;
    assign bus.forward_b    = r_fb;
    assign bus.stall_count  = r_stall_cnt;
    assign bus.flush_count  = r_flush_cnt;
    assign bus.mem_timeout  = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_fa        <= FWD_REG;
            r_fb        <= FWD_REG;
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_busy ? MEM_WAIT : RUN;
            r_wait_cnt <= w_busy ? w_wait_nxt : '0;
            if (w_busy && w_wait_nxt == WC_MAX) r_timeout <= 1'b1;
            if (!w_busy) begin
                r_wb  <= r_mem;
                r_mem <= r_ex;
                r_ex  <= (w_flush || w_stall) ? '0 : w_id;
                r_fa  <= (w_flush || w_stall) ? FWD_REG : w_fa;
                r_fb  <= (w_flush || w_stall) ? FWD_REG : w_fb;
            end
            if (w_stall && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && ~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage RV32 core. It shadows the destination register of every in-flight instruction in EX, MEM and WB, and generates the registered `forward_a`/`forward_b` selects that drive the EX-stage operand muxes. It also produces the load-use stall, the branch flush and the data-memory freeze controls for the PC and the pipeline registers. It sits beside the ID stage and is clocked with the pipeline registers.

## Interface
- `MEM_TIMEOUT`, 255: consecutive `dmem_busy` cycles before `mem_timeout` sets.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  pipeline clock
- `rst_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs1`, `id_rs2`  in  5  ID source registers
- `id_uses_rs1`, `id_uses_rs2`  in  1  source is actually read
- `id_rd`  in  5  ID destination
- `id_reg_write`  in  1  ID writes rd
- `id_mem_read`  in  1  ID is a load
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX
- `dmem_busy`  in  1  data memory not ready this cycle
- `forward_a`, `forward_b`  out  2  operand select: 00 register file, 01 MEM/WB, 10 EX/MEM; 11 never driven
- `pc_write`  out  1  PC enable
- `if_id_write`  out  1  IF/ID enable
- `if_id_flush`  out  1  IF/ID clear to NOP
- `id_ex_bubble`  out  1  ID/EX loads NOP
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM, MEM/WB
- `stall_count`, `flush_count`  out  CNT_W  saturating event counters
- `mem_timeout`  out  1  sticky error

## Operation
- Shadow stages `ex_*`, `mem_*` and `wb_*` each hold `{rd, reg_write, mem_read}`. They advance whenever `pipe_freeze` = 0: `wb` loads `mem`, `mem` loads `ex`, and `ex` loads ID or a bubble (all zero).
- An ID entry is a bubble when `id_valid` = 0.
- An operand matches a stage when all of these hold: the operand is used, `rd` equals the source register, `reg_write` = 1 and `rd` != 0. x0 is never forwarded.
- Load-use hazard: `ex_mem_read` = 1 and the EX stage matches rs1 or rs2 of the ID instruction.
- Per-cycle priority: freeze > flush > load-use > normal.
  - Freeze (`dmem_busy` = 1):
    - `pipe_freeze`=1, `pc_write`=0, `if_id_write`=0, flush=0, bubble=0.
    - Shadows and forward selects hold.
  - Flush (`ex_branch_taken` = 1):
    - `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1.
    - `ex` shadow loads a bubble; forward selects load 00.
    - `flush_count` increments.
  - Load-use:
    - `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
    - `ex` shadow loads a bubble; forward selects load 00.
    - `stall_count` increments.
  - Normal:
    - `pc_write`=1, `if_id_write`=1.
    - For each operand, the registered select loads 10 if the `ex` shadow matches, otherwise 01 if the `mem` shadow matches, otherwise 00. EX priority gives the youngest result.
- FSM `RUN`/`MEM_WAIT`:
  - `RUN` → `MEM_WAIT` on `dmem_busy`.
  - `MEM_WAIT` → `RUN` on `!dmem_busy`.
  - The wait counter clears on entry to `MEM_WAIT` and counts up while in it.
  - When the counter reaches `MEM_TIMEOUT`, `mem_timeout` sets and stays set until reset.
- Counters saturate at all-ones and never wrap.

## Timing
- Forward selects are registered. They are computed in the cycle the instruction is in ID and are valid for the whole cycle that instruction spends in EX. Latency is 1 clock.
- All stall, flush and freeze outputs are combinational from the inputs, the shadows and the state. They take effect at the next clock edge.
- Reset (asynchronous, any cycle, including mid-freeze or mid-stall):
  - Shadows cleared, forward selects 00, state `RUN`, counters 0, `mem_timeout` 0.
  - While `rst_n` = 0: `pc_write`=0, `if_id_write`=0, `pipe_freeze`=1, `if_id_flush`=0, `id_ex_bubble`=0.
- Branch and load-use in the same cycle: only the flush applies and only `flush_count` increments.
- Freeze plus any other event in the same cycle: only the freeze applies. The flush or stall is re-evaluated in the first cycle after busy drops.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - `fwd_sel_t` enum: `FWD_REG`=2'b00, `FWD_MEM_WB`=2'b01, `FWD_EX_MEM`=2'b10.
  - `ctrl_state_t` enum.
  - `shadow_t` struct `{rd, reg_write, mem_read}`.
- One sub-module, `fwd_sel_calc`:
  - Combinational match and priority logic for a single operand.
  - Instantiated twice, once for A and once for B.

## Test plan
- Back-to-back ALU ops, `add x5,..` then `sub x6,x5,x5`: `forward_a` = `forward_b` = 10 during the sub's EX cycle.
- Producer on x7, one unrelated instruction, then a consumer of x7 in rs2: `forward_b` = 01 and `forward_a` = 00.
- Both EX and MEM write x3, consumer reads x3: select = 10. Writer to x0, consumer reads x0: select = 00.
- `lw x4` then `add x8,x4,x1`:
  - One cycle with `pc_write`=0 and `id_ex_bubble`=1.
  - Then `forward_a` = 01 in the add's EX cycle.
  - `stall_count` = 1.
- Load-use coincident with `ex_branch_taken`: flush only, `flush_count` = 1, `stall_count` = 0.
- `dmem_busy` held for 255 cycles with `MEM_TIMEOUT`=255:
  - Shadows and selects frozen throughout; `mem_timeout` sets.
  - Assert `rst_n` low mid-freeze: all outputs take their reset values immediately.
